ysyx_24080006_mem_arbiter: RTL

// - Shares one AXI4-Lite master port between the IFU (icache refill, read-only) and the LSU (load/store).
// - Sits between the core and the SoC/sim memory bus. Runs one outstanding transaction at a time.
// - Builds LSU write strobes and lane-shifted write data from lsu_size and addr[1:0].

---
 rtl/ysyx_24080006_pkg.sv | 9 +
 rtl/ysyx_24080006_arb_pick.sv | 30 +++
 rtl/ysyx_24080006_mem_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared types for the memory arbiter (FSM states, grant ids, store strobe table).
package ysyx_24080006_pkg;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} arb_state_e;
  typedef enum logic {GNT_IFU, GNT_LSU} arb_grant_e;
  localparam logic [3:0][3:0] WSTRB_LUT = {4'b0000, 4'b1111, 4'b0011, 4'b0001};
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == 2'd3 || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
  endfunction
endpackage

// File: rtl/ysyx_24080006_arb_pick.sv
// ysyx_24080006_arb_pick: IFU/LSU grant selection; defining YSYX_24080006_ARB_RR_EN selects
// round-robin (last winner loses a tie), otherwise fixed priority by IFU_PRIO.
module ysyx_24080006_arb_pick
  import ysyx_24080006_pkg::*;
#(
  parameter int IFU_PRIO = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       take,
  output arb_grant_e gnt
);
  arb_grant_e tie;
`ifdef YSYX_24080006_ARB_RR_EN
  arb_grant_e last_q;
  logic unused_prio;
  assign unused_prio = IFU_PRIO != 0;
  assign tie = last_q == GNT_LSU ? GNT_IFU : GNT_LSU;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_q <= GNT_LSU;
    else if (take) last_q <= gnt;
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clock, reset_n, take};
  assign tie = IFU_PRIO != 0 ? GNT_IFU : GNT_LSU;
`endif
  assign gnt = ifu_valid && lsu_valid ? tie : ifu_valid ? GNT_IFU : GNT_LSU;
endmodule

// File: rtl/ysyx_24080006_mem_arbiter.sv
// ysyx_24080006_mem_arbiter: shares one AXI4-Lite master between IFU fetches and LSU loads/stores,
// one transaction at a time; YSYX_24080006_ARB_RR_EN switches the tie-break to round-robin.
module ysyx_24080006_mem_arbiter
  import ysyx_24080006_pkg::*;
#(
  parameter int IFU_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_write,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);
  arb_state_e state, state_n;
  arb_grant_e gnt, gnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic aw_done, w_done, take, lsu_win, mis, r_done, b_done, unused_ifu_off;
  ysyx_24080006_arb_pick #(.IFU_PRIO(IFU_PRIO)) u_pick (
    .clock    (clock),
    .reset_n  (reset_n),
    .ifu_valid(ifu_req_valid),
    .lsu_valid(lsu_req_valid),
    .take     (take),
    .gnt      (gnt)
  );
  assign unused_ifu_off = ^ifu_addr[1:0];
  assign take = state == IDLE && (ifu_req_valid || lsu_req_valid);
  assign lsu_win = gnt == GNT_LSU;
  assign mis = misaligned(lsu_size, lsu_addr[1:0]);
  assign ifu_req_ready = take && !lsu_win;
  assign lsu_req_ready = take && lsu_win;
  assign r_done = state == RDATA && m_rvalid;
  assign b_done = state == WRESP && m_bvalid;
  assign m_arvalid = state == RADDR;
  assign m_rready = state == RDATA;
  assign m_awvalid = state == WADDR && !aw_done;
  assign m_wvalid = state == WADDR && !w_done;
  assign m_bready = state == WRESP;
  assign m_araddr = addr_q;
  assign m_awaddr = addr_q;
  assign m_wdata = wdata_q;
  assign m_wstrb = wstrb_q;
  assign m_arprot = 3'd0;
  assign m_awprot = 3'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take && !(lsu_win && mis)) state_n = lsu_win && lsu_write ? WADDR : RADDR;
      RADDR:   if (m_arready) state_n = RDATA;
      RDATA:   if (m_rvalid) state_n = IDLE;
      WADDR:   if ((aw_done || m_awready) && (w_done || m_wready)) state_n = WRESP;
      WRESP:   if (m_bvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Responses are registered, so the pulse coincides with the return to IDLE.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gnt_q <= GNT_IFU;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data <= '0;
      ifu_rsp_err <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data <= '0;
      lsu_rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      ifu_rsp_valid <= r_done && gnt_q == GNT_IFU;
      lsu_rsp_valid <= (r_done && gnt_q == GNT_LSU) || b_done || (lsu_req_ready && mis);
      if (r_done && gnt_q == GNT_IFU) {ifu_rsp_data, ifu_rsp_err} <= {m_rdata, m_rresp != 2'd0};
      if (r_done && gnt_q == GNT_LSU) {lsu_rsp_data, lsu_rsp_err} <= {m_rdata, m_rresp != 2'd0};
      if (b_done) lsu_rsp_err <= m_bresp != 2'd0;
      if (lsu_req_ready && mis) lsu_rsp_err <= 1'b1;
      if (take) begin
        gnt_q <= gnt;
        addr_q <= {lsu_win ? lsu_addr[31:2] : ifu_addr[31:2], 2'b00};
        wstrb_q <= WSTRB_LUT[lsu_size] << lsu_addr[1:0];
        wdata_q <= lsu_wdata << {lsu_addr[1:0], 3'b000};
      end
      aw_done <= state == WADDR && (aw_done || m_awready);
      w_done <= state == WADDR && (w_done || m_wready);
    end
endmodule
